bcd_seg7_scan: RTL and testbench



---
 rtl/bcd_disp_pkg.sv | 22 ++
 rtl/seg7_enc.sv | 27 ++
 rtl/bcd_seg7_scan.sv | 134 +++++++++++++
 tb/tb_bcd_seg7_scan.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and 7-segment patterns for the multiplexed BCD display path.
// Segment patterns are active-high, bit order g..a.
package bcd_disp_pkg;

    localparam int NUM_DIG = 3;

    typedef logic [1:0] dig_idx_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_enc.sv
// Combinational BCD nibble to active-high 7-segment pattern (g..a).
// Non-BCD nibbles render as a dash so corrupted input is visible.
module seg7_enc
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// 3-digit multiplexed 7-segment scanner with anti-ghost blank gap,
// leading-zero blanking and frame-aligned (tear-free) value update.
module bcd_seg7_scan
    import bcd_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLANK_CYC   = 500,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          DIG_ACT_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [11:0]        bcd_in,
    input  logic               bcd_vld,
    input  logic               lz_en,
    input  logic [NUM_DIG-1:0] dp_in,
    output logic [7:0]         seg_out,
    output logic [NUM_DIG-1:0] dig_out,
    output logic               frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam dig_idx_t         DIG_LAST = dig_idx_t'(NUM_DIG - 1);

    logic [CNT_W-1:0]   cnt;
    dig_idx_t           idx;
    logic [11:0]        disp;
    logic [11:0]        pend;
    logic               pend_flag;

    logic               cnt_wrap;
    logic               frame_wrap;
    logic               blank_slot;
    logic               digit_blank;
    logic [3:0]         nib;
    logic [6:0]         seg_pat;
    logic [7:0]         seg_nxt;
    logic [NUM_DIG-1:0] dig_nxt;

    logic [7:0]         seg_p1;
    logic [NUM_DIG-1:0] dig_p1;

    function automatic logic [7:0] seg_pol(input logic [7:0] s);
        return SEG_ACT_LOW ? ~s : s;
    endfunction

    function automatic logic [NUM_DIG-1:0] dig_pol(input logic [NUM_DIG-1:0] d);
        return DIG_ACT_LOW ? ~d : d;
    endfunction

    assign cnt_wrap   = (cnt == CNT_LAST);
    assign frame_wrap = cnt_wrap && (idx == DIG_LAST);
    assign blank_slot = (32'(cnt) < BLANK_CYC);

    // Scan counters; disp only changes on the frame wrap so a frame never mixes two values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_flag  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cnt_wrap) begin
                cnt <= '0;
                if (idx == DIG_LAST) begin
                    idx        <= '0;
                    frame_done <= 1'b1;
                    if (pend_flag) begin
                        disp      <= pend;
                        pend_flag <= 1'b0;
                    end
                end else begin
                    idx <= idx + 2'd1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
            // A strobe on the wrap cycle must stay pending, so it overrides the clear above.
            if (bcd_vld) begin
                pend      <= bcd_in;
                pend_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        nib = disp[3:0];
        case (idx)
            2'd0:    nib = disp[3:0];
            2'd1:    nib = disp[7:4];
            default: nib = disp[11:8];
        endcase
    end

    seg7_enc u_enc (
        .nib (nib),
        .seg (seg_pat)
    );

    always_comb begin
        digit_blank = 1'b0;
        seg_nxt     = 8'h00;
        dig_nxt     = '0;
        if (lz_en) begin
            if (idx == 2'd2)
                digit_blank = (disp[11:8] == 4'd0);
            else if (idx == 2'd1)
                digit_blank = (disp[11:8] == 4'd0) && (disp[7:4] == 4'd0);
        end
        if (!blank_slot) begin
            seg_nxt = {dp_in[idx], digit_blank ? SEG_BLANK : seg_pat};
            dig_nxt = {{(NUM_DIG-1){1'b0}}, 1'b1} << idx;
        end
    end

    // ---- output stage (p1): active-high registered, polarity applied after ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_p1 <= 8'h00;
            dig_p1 <= '0;
        end else begin
            seg_p1 <= seg_nxt;
            dig_p1 <= dig_nxt;
        end
    end

    assign seg_out = seg_pol(seg_p1);
    assign dig_out = dig_pol(dig_p1);

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Scoreboard bench for bcd_seg7_scan: stimulus queues expected per-frame slot
// patterns, the monitor checks every cycle of each targeted frame.
module tb_bcd_seg7_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic        bcd_vld = 1'b0;
    logic        lz_en = 1'b0;
    logic [2:0]  dp_in = 3'b000;
    logic [7:0]  seg_out;
    logic [2:0]  dig_out;
    logic        frame_done;

    bcd_seg7_scan #(
        .SCAN_DIV    (4),
        .BLANK_CYC   (1),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .bcd_vld    (bcd_vld),
        .lz_en      (lz_en),
        .dp_in      (dp_in),
        .seg_out    (seg_out),
        .dig_out    (dig_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int             frame;
        int             test;
        logic [2:0][7:0] seg;   // [0]=units slot, [2]=hundreds slot
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int passed = 0;
    int frame_cnt = -1;
    int pos = 0;
    bit prev_fd = 1'b0;
    bit in_frame = 1'b0;

    task automatic push(input int f, input int t, input logic [7:0] s0,
                        input logic [7:0] s1, input logic [7:0] s2);
        exp_t e;
        e.frame = f;
        e.test  = t;
        e.seg   = {s2, s1, s0};
        sb.push_back(e);
    endtask

    // Monitor: a frame starts the cycle after frame_done (or after reset release).
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (seg_out == 8'hFF && dig_out == 3'b111 && frame_done == 1'b0)
                passed++;
            else
                $display("FAIL reset_off: seg=%h dig=%b fd=%b required seg=ff dig=111 fd=0",
                         seg_out, dig_out, frame_done);
            prev_fd  = 1'b1;
            in_frame = 1'b0;
        end else begin
            if (prev_fd) begin
                frame_cnt++;
                pos      = 0;
                in_frame = 1'b1;
            end else begin
                pos++;
            end
            prev_fd = frame_done;
            if (sb.size() > 0 && pos == 0 && sb[0].frame < frame_cnt) begin
                checks++;
                $display("FAIL missed_frame: test%0d frame %0d expected, now at frame %0d",
                         sb[0].test, sb[0].frame, frame_cnt);
                void'(sb.pop_front());
            end
            if (in_frame && sb.size() > 0 && sb[0].frame == frame_cnt) begin
                checks++;
                if (pos > 11) begin
                    $display("FAIL frame_len: test%0d frame %0d pos %0d without frame_done",
                             sb[0].test, frame_cnt, pos);
                    void'(sb.pop_front());
                end else begin
                    int          slot;
                    logic [7:0]  es;
                    logic [2:0]  ed;
                    logic        ef;
                    slot = pos / 4;
                    ef   = (pos == 11);
                    if (pos % 4 == 0) begin
                        es = 8'hFF;
                        ed = 3'b111;
                    end else begin
                        es = sb[0].seg[slot];
                        ed = ~(3'b001 << slot);
                    end
                    if (seg_out == es && dig_out == ed && frame_done == ef)
                        passed++;
                    else
                        $display("FAIL test%0d frame%0d pos%0d: seg=%h dig=%b fd=%b required seg=%h dig=%b fd=%b",
                                 sb[0].test, frame_cnt, pos, seg_out, dig_out, frame_done, es, ed, ef);
                    if (pos == 11)
                        void'(sb.pop_front());
                end
            end
        end
    end

    task automatic go_to(input int f, input int p);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && in_frame && frame_cnt == f && pos == p) return;
            n++;
            if (n > 400) begin
                checks++;
                $display("FAIL wait_frame: frame %0d pos %0d not reached, at frame %0d pos %0d",
                         f, p, frame_cnt, pos);
                return;
            end
        end
    endtask

    task automatic strobe(input logic [11:0] v);
        bcd_in  = v;
        bcd_vld = 1'b1;
        @(posedge clk);
        #1;
        bcd_vld = 1'b0;
    endtask

    initial begin
        int n;
        // 1. reset, then power-on value 000 shown as "0" in every slot
        push(0, 1, 8'hC0, 8'hC0, 8'hC0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // 2. 123, no blanking; two consecutive frames
        go_to(0, 5);
        strobe(12'h123);
        push(1, 2, 8'hB0, 8'hA4, 8'hF9);
        push(2, 2, 8'hB0, 8'hA4, 8'hF9);

        // 3. 007 with and without leading-zero blanking
        go_to(3, 5);
        lz_en = 1'b1;
        strobe(12'h007);
        push(4, 3, 8'hF8, 8'hFF, 8'hFF);
        go_to(5, 5);
        lz_en = 1'b0;
        push(6, 3, 8'hF8, 8'hC0, 8'hC0);

        // 4. all-zero blanked, invalid nibble dash, decimal points
        go_to(7, 5);
        lz_en = 1'b1;
        strobe(12'h000);
        push(8, 4, 8'hC0, 8'hFF, 8'hFF);
        go_to(9, 5);
        lz_en = 1'b0;
        dp_in = 3'b001;
        strobe(12'h0A5);
        push(10, 4, 8'h12, 8'hBF, 8'hC0);
        go_to(11, 5);
        lz_en = 1'b1;
        dp_in = 3'b100;
        strobe(12'h005);
        push(12, 4, 8'h92, 8'hFF, 8'h7F);

        // 5. last strobe before wrap wins; strobe on the wrap cycle waits a frame
        go_to(13, 5);
        lz_en = 1'b0;
        dp_in = 3'b000;
        strobe(12'h111);
        go_to(13, 9);
        strobe(12'h222);
        push(14, 5, 8'hA4, 8'hA4, 8'hA4);
        go_to(15, 10);
        strobe(12'h456);
        push(16, 5, 8'hA4, 8'hA4, 8'hA4);
        push(17, 5, 8'h82, 8'h92, 8'h99);

        // 6. reset while a digit is lit and 789 is pending
        go_to(18, 2);
        strobe(12'h789);
        go_to(18, 6);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        push(19, 6, 8'hC0, 8'hC0, 8'hC0);
        push(20, 6, 8'hC0, 8'hC0, 8'hC0);
        #1 rst_n = 1'b1;

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expected frames never observed", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
